// File: rtl/x7seg_scan_n.sv
// x7seg_scan_n
// Multiplexed 7-segment display driver for DIGITS digits.
// The scan prescaler, digit slot and PWM counter run continuously.
// New values are staged and only become visible at a frame boundary,
// so a frame is never drawn half old and half new.
// All outputs come straight from registers. Polarity is applied on the way into those registers.

module x7seg_scan_n #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            a_to_g,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);

    localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};

    // Hex to segment pattern, a is the MSB.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [3:0]          pwm_q, pwm_d;
    logic [4*DIGITS-1:0] stg_x_q, stg_x_d;
    logic [DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [4*DIGITS-1:0] act_x_q, act_x_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic                pend_q, pend_d;

    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                fd_q;

    logic                tick;
    logic                wrap;
    logic                gate;
    logic                zeros_above;
    logic [DIGITS-1:0]   blank_v;
    logic [DIGITS-1:0]   onehot;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;

    // Scan timing: the prescaler sets the slot dwell, and the slot wraps at the last digit.
    always_comb begin
        tick    = (presc_q == PRE_LAST);
        wrap    = tick && (slot_q == SLOT_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        slot_d  = slot_q;
        if (tick) begin
            slot_d = wrap ? '0 : slot_q + 1'b1;
        end
        pwm_d = pwm_q + 4'd1;
    end

    // Double buffer.
    // A load that coincides with the frame boundary bypasses staging, so it is never delayed a whole frame.
    always_comb begin
        stg_x_d  = stg_x_q;
        stg_dp_d = stg_dp_q;
        act_x_d  = act_x_q;
        act_dp_d = act_dp_q;
        pend_d   = pend_q;
        if (load && wrap) begin
            act_x_d  = x;
            act_dp_d = dp_in;
            pend_d   = 1'b0;
        end else if (load) begin
            stg_x_d  = x;
            stg_dp_d = dp_in;
            pend_d   = 1'b1;
        end else if (wrap && pend_q) begin
            act_x_d  = stg_x_q;
            act_dp_d = stg_dp_q;
            pend_d   = 1'b0;
        end
    end

    // Leading-zero map, then pick out the digit under the current slot.
    always_comb begin
        zeros_above = 1'b1;
        blank_v     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above & (act_x_q[4*i +: 4] == 4'h0);
            blank_v[i]  = blank_lz && (i != 0) && zeros_above;
        end
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_nib   = act_x_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = blank_v[i];
                onehot[i] = 1'b1;
            end
        end
    end

    // Output pattern for the current slot.
    // Brightness only gates the anodes; segments keep showing the digit.
    always_comb begin
        gate  = (bright == 4'hF) || (pwm_q < bright);
        an_d  = (gate && !cur_blank) ? onehot : '0;
        seg_d = cur_blank ? 7'b0000000 : decode(cur_nib);
        dp_d  = cur_dp;
    end

    // State and output registers. Reset leaves the display dark in the selected polarity.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q  <= '0;
            slot_q   <= '0;
            pwm_q    <= 4'd0;
            stg_x_q  <= '0;
            stg_dp_q <= '0;
            act_x_q  <= '0;
            act_dp_q <= '0;
            pend_q   <= 1'b0;
            an_q     <= AN_POL;
            seg_q    <= SEG_POL;
            dp_q     <= ACTIVE_LOW;
            fd_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            slot_q   <= slot_d;
            pwm_q    <= pwm_d;
            stg_x_q  <= stg_x_d;
            stg_dp_q <= stg_dp_d;
            act_x_q  <= act_x_d;
            act_dp_q <= act_dp_d;
            pend_q   <= pend_d;
            an_q     <= an_d ^ AN_POL;
            seg_q    <= seg_d ^ SEG_POL;
            dp_q     <= dp_d ^ ACTIVE_LOW;
            fd_q     <= wrap;
        end
    end

    assign an         = an_q;
    assign a_to_g     = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_x7seg_scan_n.sv
// Bench for x7seg_scan_n.
// Two configurations run side by side on the same stimulus:
//   A: DIGITS=4, PRESCALE=1, active high.
//   B: DIGITS=6, PRESCALE=3, active low.
// The reference derives slot, PWM phase and frame boundary arithmetically from the cycle count since reset.

module tb_x7seg_scan_n;

    logic        clk;
    logic        clr;
    logic [31:0] x;
    logic [7:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  bright;

    logic [3:0]  an_a;
    logic [6:0]  seg_a;
    logic        dp_a;
    logic        fd_a;
    logic [5:0]  an_b;
    logic [6:0]  seg_b;
    logic        dp_b;
    logic        fd_b;

    x7seg_scan_n #(.DIGITS(4), .PRESCALE(1), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .clr(clr), .x(x[15:0]), .dp_in(dp_in[3:0]), .load(load),
        .blank_lz(blank_lz), .bright(bright),
        .an(an_a), .a_to_g(seg_a), .dp(dp_a), .frame_done(fd_a)
    );

    x7seg_scan_n #(.DIGITS(6), .PRESCALE(3), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .clr(clr), .x(x[23:0]), .dp_in(dp_in[5:0]), .load(load),
        .blank_lz(blank_lz), .bright(bright),
        .an(an_b), .a_to_g(seg_b), .dp(dp_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int cfg_d  [2] = '{4, 6};
    int cfg_p  [2] = '{1, 3};
    bit cfg_al [2] = '{1'b0, 1'b1};

    int          m_n    [2];
    logic [31:0] m_ax   [2];
    logic [7:0]  m_adp  [2];
    logic [31:0] m_sx   [2];
    logic [7:0]  m_sdp  [2];
    bit          m_pend [2];
    logic [7:0]  e_an   [2];
    logic [6:0]  e_seg  [2];
    logic        e_dp   [2];
    logic        e_fd   [2];

    function automatic logic [31:0] xmask(input int d);
        logic [63:0] one;
        one = 64'd1;
        return 32'((one << (4 * d)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k]    = 0;
            m_ax[k]   = 32'h0;
            m_adp[k]  = 8'h0;
            m_sx[k]   = 32'h0;
            m_sdp[k]  = 8'h0;
            m_pend[k] = 1'b0;
        end
    endtask

    // Expected outputs for the edge about to happen, then advance the buffer state.
    task automatic model_edge(input int k);
        int d, p, slot, pwm;
        bit al, wrap, blk, gate;
        logic [3:0]  nib;
        logic [7:0]  an_v, dmask, dpin;
        logic [6:0]  sg;
        logic [31:0] xin;
        d     = cfg_d[k];
        p     = cfg_p[k];
        al    = cfg_al[k];
        slot  = (m_n[k] / p) % d;
        pwm   = m_n[k] % 16;
        wrap  = ((m_n[k] % p) == p - 1) && (slot == d - 1);
        nib   = m_ax[k][4*slot +: 4];
        blk   = blank_lz && (slot != 0) && ((m_ax[k] >> (4 * slot)) == 32'h0);
        gate  = (bright == 4'hF) || (pwm < int'(bright));
        dmask = 8'((1 << d) - 1);
        an_v  = (gate && !blk) ? 8'(1 << slot) : 8'h0;
        sg    = blk ? 7'h0 : seg_tab[nib];
        e_an[k]  = al ? (~an_v & dmask) : an_v;
        e_seg[k] = al ? ~sg : sg;
        e_dp[k]  = m_adp[k][slot] ^ al;
        e_fd[k]  = wrap;
        xin  = x & xmask(d);
        dpin = dp_in & dmask;
        if (load && wrap) begin
            m_ax[k]   = xin;
            m_adp[k]  = dpin;
            m_pend[k] = 1'b0;
        end else if (load) begin
            m_sx[k]   = xin;
            m_sdp[k]  = dpin;
            m_pend[k] = 1'b1;
        end else if (wrap && m_pend[k]) begin
            m_ax[k]   = m_sx[k];
            m_adp[k]  = m_sdp[k];
            m_pend[k] = 1'b0;
        end
        m_n[k]++;
    endtask

    task automatic check_all();
        chk("A.an",  32'(an_a),  32'(e_an[0][3:0]));
        chk("A.seg", 32'(seg_a), 32'(e_seg[0]));
        chk("A.dp",  32'(dp_a),  32'(e_dp[0]));
        chk("A.fd",  32'(fd_a),  32'(e_fd[0]));
        chk("B.an",  32'(an_b),  32'(e_an[1][5:0]));
        chk("B.seg", 32'(seg_b), 32'(e_seg[1]));
        chk("B.dp",  32'(dp_b),  32'(e_dp[1]));
        chk("B.fd",  32'(fd_b),  32'(e_fd[1]));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".A.an"},  32'(an_a),  32'h0);
        chk({tag, ".A.seg"}, 32'(seg_a), 32'h0);
        chk({tag, ".A.dp"},  32'(dp_a),  32'h0);
        chk({tag, ".A.fd"},  32'(fd_a),  32'h0);
        chk({tag, ".B.an"},  32'(an_b),  32'h3F);
        chk({tag, ".B.seg"}, 32'(seg_b), 32'h7F);
        chk({tag, ".B.dp"},  32'(dp_b),  32'h1);
        chk({tag, ".B.fd"},  32'(fd_b),  32'h0);
    endtask

    // Called at a negedge: drive inputs, take one rising edge, and check just after it.
    task automatic step(input logic ld, input logic [31:0] xv, input logic [7:0] dv);
        load  = ld;
        x     = xv;
        dp_in = dv;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 8'h0);
    endtask

    initial begin
        int r;
        clr      = 1'b1;
        x        = 32'h0;
        dp_in    = 8'h0;
        load     = 1'b0;
        blank_lz = 1'b0;
        bright   = 4'hF;
        model_reset();
        #12;
        check_reset("rst");
        @(negedge clk);
        clr = 1'b0;

        // Plain scan of 1234 at full brightness.
        step(1'b1, 32'h0000_1234, 8'h00);
        idle(12);

        // Load in the middle of a frame; it must wait for the boundary.
        r = (5 - (m_n[0] % 4)) % 4;
        idle(r);
        step(1'b1, 32'h0000_ABCD, 8'h00);
        idle(10);

        // Leading-zero blanking, then an all-zero value.
        blank_lz = 1'b1;
        step(1'b1, 32'h0000_0050, 8'h00);
        idle(10);
        step(1'b1, 32'h0000_0000, 8'h00);
        idle(10);

        // PWM duty, then fully off.
        blank_lz = 1'b0;
        step(1'b1, 32'h0000_1234, 8'h00);
        bright = 4'd4;
        idle(64);
        bright = 4'd0;
        idle(32);

        // F on digit 0 with its decimal point; B shows the active-low form.
        bright = 4'hF;
        step(1'b1, 32'h0000_000F, 8'h01);
        idle(30);

        // Two loads in one frame: the later one wins.
        step(1'b1, 32'h0012_3456, 8'h05);
        step(1'b1, 32'h0065_4321, 8'h22);
        idle(24);

        // Asynchronous reset mid-frame with a load still pending.
        step(1'b1, 32'h0000_1234, 8'h03);
        idle(2);
        step(1'b1, 32'h0000_5678, 8'h0C);
        #8;
        clr = 1'b1;
        #1;
        check_reset("arst");
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        idle(20);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        ld;
            logic [31:0] xv;
            if ($urandom_range(0, 40) == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 60) == 0) blank_lz = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 5) == 0);
            xv = $urandom;
            if ($urandom_range(0, 2) == 0) xv = xv >> (4 * $urandom_range(1, 7));
            step(ld, xv, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
